ex_pipe: RTL and testbench

EX_PIPE -- requirements
Module: ex_pipe

---
 rtl/ex_pkg.sv | 35 +++
 rtl/ex_muldiv.sv | 128 ++++++++++++
 rtl/ex_pipe.sv | 167 ++++++++++++++++
 tb/tb_ex_pipe.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// ---------------------------------------------------------------------------
// ex_pkg
// Purpose : Definitions shared by the execute pipe: the default operand
//           width, the ALU operation codes and the encoding of the
//           control FSM.
// Contents: DEFAULT_DATA_W, OP_* operation codes, ST_* FSM state constants,
//           and is_muldiv_op(), which picks out the multi-cycle operations.
// ---------------------------------------------------------------------------
package ex_pkg;

    localparam int DEFAULT_DATA_W = 32;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLTU = 4'd8;
    localparam logic [3:0] OP_MUL  = 4'd9;
    localparam logic [3:0] OP_DIVU = 4'd10;
    localparam logic [3:0] OP_REMU = 4'd11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    // True for the operations that run through the iterative datapath.
    function automatic logic is_muldiv_op(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/ex_muldiv.sv
// ---------------------------------------------------------------------------
// ex_muldiv
// Purpose : Iterative unsigned multiply (shift-add, low half of the product)
//           and unsigned divide/remainder (restoring). Each operation takes
//           one bit per cycle, DATA_W cycles in all.
// Ports   : clk, rst_n       - clock, asynchronous active-low reset
//           start            - load operands and begin (ignored bits of op
//                              other than MUL/DIVU/REMU select DIVU)
//           op               - OP_MUL, OP_DIVU or OP_REMU
//           a, b             - operand A, operand B
//           done             - high during the final iteration cycle
//           result           - valid while done is high
// ---------------------------------------------------------------------------
module ex_muldiv
    import ex_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    localparam int CNT_W = $clog2(DATA_W);

    logic              active_q,  active_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic              is_mul_q,  is_mul_d;
    logic              want_rem_q, want_rem_d;
    // acc: product accumulator (MUL) or partial remainder (DIVU/REMU)
    logic [DATA_W-1:0] acc_q,     acc_d;
    // sh: multiplier shifting right (MUL) or dividend shifting out while
    //     quotient bits shift in (DIVU/REMU)
    logic [DATA_W-1:0] sh_q,      sh_d;
    // opb: multiplicand shifting left (MUL) or fixed divisor (DIVU/REMU)
    logic [DATA_W-1:0] opb_q,     opb_d;

    logic [DATA_W-1:0] acc_step;
    logic [DATA_W-1:0] sh_step;
    logic [DATA_W-1:0] opb_step;
    logic [DATA_W:0]   trial;
    logic [DATA_W:0]   diff;

    // One iteration of the selected algorithm. For division the divisor is
    // trial-subtracted from the shifted remainder; a borrow out of the top
    // bit means the subtraction is undone and a 0 quotient bit is recorded.
    // A zero divisor never borrows, which naturally yields an all-ones
    // quotient and leaves the dividend as the remainder.
    always_comb begin
        acc_step = acc_q;
        sh_step  = sh_q;
        opb_step = opb_q;
        trial    = {acc_q, sh_q[DATA_W-1]};
        diff     = trial - {1'b0, opb_q};
        if (is_mul_q) begin
            acc_step = acc_q + (sh_q[0] ? opb_q : '0);
            sh_step  = sh_q >> 1;
            opb_step = opb_q << 1;
        end else if (!diff[DATA_W]) begin
            acc_step = diff[DATA_W-1:0];
            sh_step  = {sh_q[DATA_W-2:0], 1'b1};
        end else begin
            acc_step = trial[DATA_W-1:0];
            sh_step  = {sh_q[DATA_W-2:0], 1'b0};
        end
    end

    // The last iteration is combinational so the result can be registered
    // by the caller in the same cycle the counter reaches its end.
    assign done   = active_q && (cnt_q == CNT_W'(DATA_W - 1));
    assign result = (is_mul_q || want_rem_q) ? acc_step : sh_step;

    // Operand loading on start, then one iteration per cycle until done.
    always_comb begin
        active_d   = active_q;
        cnt_d      = cnt_q;
        is_mul_d   = is_mul_q;
        want_rem_d = want_rem_q;
        acc_d      = acc_q;
        sh_d       = sh_q;
        opb_d      = opb_q;
        if (start) begin
            active_d   = 1'b1;
            cnt_d      = '0;
            is_mul_d   = (op == OP_MUL);
            want_rem_d = (op == OP_REMU);
            acc_d      = '0;
            sh_d       = (op == OP_MUL) ? b : a;
            opb_d      = (op == OP_MUL) ? a : b;
        end else if (active_q) begin
            acc_d = acc_step;
            sh_d  = sh_step;
            opb_d = opb_step;
            if (done) begin
                active_d = 1'b0;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q   <= 1'b0;
            cnt_q      <= '0;
            is_mul_q   <= 1'b0;
            want_rem_q <= 1'b0;
            acc_q      <= '0;
            sh_q       <= '0;
            opb_q      <= '0;
        end else begin
            active_q   <= active_d;
            cnt_q      <= cnt_d;
            is_mul_q   <= is_mul_d;
            want_rem_q <= want_rem_d;
            acc_q      <= acc_d;
            sh_q       <= sh_d;
            opb_q      <= opb_d;
        end
    end

endmodule

// File: rtl/ex_pipe.sv
// ---------------------------------------------------------------------------
// ex_pipe
// Purpose : Execute stage with a valid/ready handshake on both sides.
//           Single-cycle ALU ops produce a registered result one cycle after
//           acceptance; MUL/DIVU/REMU run in ex_muldiv (when MULDIV_EN=1)
//           and present their result DATA_W+1 cycles after acceptance.
// Ports   : clk, rst_n            - clock, asynchronous active-low reset
//           in_valid / in_ready   - operation handshake
//           rD1                   - operand A
//           rD2, ext, alub_sel    - operand B source (0 = rD2, 1 = ext)
//           alu_op                - operation code (see ex_pkg)
//           out_valid / out_ready - result handshake
//           res                   - registered result
//           flag                  - {sign, zero} of res
// ---------------------------------------------------------------------------
module ex_pipe
    import ex_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int MULDIV_EN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] rD1,
    input  logic [DATA_W-1:0] rD2,
    input  logic [DATA_W-1:0] ext,
    input  logic              alub_sel,
    input  logic [3:0]        alu_op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] res,
    output logic [1:0]        flag
);

    localparam int SH_W = $clog2(DATA_W);

    logic [1:0]        state_q,     state_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] res_q,       res_d;
    logic [1:0]        flag_q,      flag_d;

    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    logic [SH_W-1:0]   shamt;
    logic [DATA_W-1:0] alu_res;
    logic [1:0]        alu_flag;
    logic              op_is_muldiv;
    logic              accept;
    logic              md_start;
    logic              md_done;
    logic [DATA_W-1:0] md_result;
    logic [1:0]        md_flag;

    // A new op can enter when idle, or when the held result leaves in the
    // same cycle; the iterative unit blocks intake while it runs.
    assign in_ready     = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready);
    assign accept       = in_valid && in_ready;
    assign op_is_muldiv = (MULDIV_EN != 0) && is_muldiv_op(alu_op);
    assign md_start     = accept && op_is_muldiv;

    assign opa   = rD1;
    assign opb   = alub_sel ? ext : rD2;
    assign shamt = opb[SH_W-1:0];

    // Single-cycle ALU. Anything not listed (including MUL/DIVU/REMU when
    // the iterative unit is absent) is illegal and yields zero, which in
    // turn produces the zero flag.
    always_comb begin
        alu_res = '0;
        case (alu_op)
            OP_ADD:  alu_res = opa + opb;
            OP_SUB:  alu_res = opa - opb;
            OP_AND:  alu_res = opa & opb;
            OP_OR:   alu_res = opa | opb;
            OP_XOR:  alu_res = opa ^ opb;
            OP_SLL:  alu_res = opa << shamt;
            OP_SRL:  alu_res = opa >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(opa) >>> shamt);
            OP_SLTU: alu_res = {{(DATA_W-1){1'b0}}, (opa < opb)};
            default: alu_res = '0;
        endcase
    end

    assign alu_flag = {alu_res[DATA_W-1], (alu_res == '0)};
    assign md_flag  = {md_result[DATA_W-1], (md_result == '0)};

    generate
        if (MULDIV_EN != 0) begin : g_muldiv
            ex_muldiv #(
                .DATA_W (DATA_W)
            ) u_muldiv (
                .clk    (clk),
                .rst_n  (rst_n),
                .start  (md_start),
                .op     (alu_op),
                .a      (opa),
                .b      (opb),
                .done   (md_done),
                .result (md_result)
            );
        end else begin : g_no_muldiv
            assign md_done   = 1'b0;
            assign md_result = '0;
        end
    endgenerate

    // Control FSM. In HOLD the output handshake is applied first so that a
    // same-cycle acceptance can overwrite it with the next op's outcome.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        res_d       = res_q;
        flag_d      = flag_q;
        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if ((state_q == ST_HOLD) && out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
                if (accept) begin
                    if (op_is_muldiv) begin
                        state_d     = ST_BUSY;
                        out_valid_d = 1'b0;
                    end else begin
                        state_d     = ST_HOLD;
                        out_valid_d = 1'b1;
                        res_d       = alu_res;
                        flag_d      = alu_flag;
                    end
                end
            end
            ST_BUSY: begin
                if (md_done) begin
                    state_d     = ST_HOLD;
                    out_valid_d = 1'b1;
                    res_d       = md_result;
                    flag_d      = md_flag;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            flag_q      <= 2'b00;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
            flag_q      <= flag_d;
        end
    end

    assign out_valid = out_valid_q;
    assign res       = res_q;
    assign flag      = flag_q;

endmodule

// File: tb/tb_ex_pipe.sv
// ---------------------------------------------------------------------------
// tb_ex_pipe
// Purpose : Self-checking bench for ex_pipe (DATA_W=32, MULDIV_EN=1).
//           Expected {flag,res} values come from a behavioural model and are
//           queued when an op is accepted, then popped when the result shows.
// ---------------------------------------------------------------------------
module tb_ex_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] rD1;
    logic [31:0] rD2;
    logic [31:0] ext;
    logic        alub_sel;
    logic [3:0]  alu_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] res;
    logic [1:0]  flag;

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [33:0] exp_q[$];

    always #5 clk = ~clk;

    ex_pipe #(
        .DATA_W    (32),
        .MULDIV_EN (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rD1       (rD1),
        .rD2       (rD2),
        .ext       (ext),
        .alub_sel  (alub_sel),
        .alu_op    (alu_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .flag      (flag)
    );

    // Behavioural reference: returns {flag, res} with flag = {sign, zero}.
    function automatic logic [33:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] r;
        case (op)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = a & b;
            4'd3:    r = a | b;
            4'd4:    r = a ^ b;
            4'd5:    r = a << b[4:0];
            4'd6:    r = a >> b[4:0];
            4'd7:    r = $unsigned($signed(a) >>> b[4:0]);
            4'd8:    r = (a < b) ? 32'd1 : 32'd0;
            4'd9:    r = a * b;
            4'd10:   r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            4'd11:   r = (b == 32'd0) ? a : a % b;
            default: r = 32'd0;
        endcase
        return {r[31], (r == 32'd0), r};
    endfunction

    // Drives one op at a negedge, lets it be accepted at the next posedge,
    // optionally queues its expectation, then scrambles the inputs at the
    // following negedge so a late operand change would corrupt a bad design.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b2,
                         input logic [31:0] e, input logic sel, input bit push);
        alu_op   = op;
        rD1      = a;
        rD2      = b2;
        ext      = e;
        alub_sel = sel;
        in_valid = 1'b1;
        @(posedge clk);
        if (push) exp_q.push_back(model(op, a, sel ? e : b2));
        @(negedge clk);
        in_valid = 1'b0;
        rD1      = $urandom;
        rD2      = $urandom;
        ext      = $urandom;
        alub_sel = ~sel;
        alu_op   = 4'd2;
    endtask

    // Waits (bounded) for out_valid; lat is the cycle it appeared, counting
    // the first negedge after acceptance as cycle 1, or -1 on timeout.
    task automatic wait_result(input int bound, output int lat, output int busy);
        lat  = -1;
        busy = 0;
        for (int k = 1; k <= bound; k++) begin
            if (k > 1) @(negedge clk);
            if (out_valid === 1'b1) begin
                lat = k;
                break;
            end
            if (in_ready === 1'b0) busy++;
        end
    endtask

    task automatic test_reset();
        logic [33:0] exp;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        rD1 = '0; rD2 = '0; ext = '0; alub_sel = 1'b0; alu_op = 4'd0;
        repeat (3) @(negedge clk);
        n_compared++; if (out_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_out_valid got %0b want 0", out_valid); end
        n_compared++; if (res !== 32'd0) begin n_mismatched++; $display("[TB] FAIL reset_res got %h want 0", res); end
        n_compared++; if (flag !== 2'b00) begin n_mismatched++; $display("[TB] FAIL reset_flag got %b want 00", flag); end
        n_compared++; if (in_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reset_in_ready got %0b want 1", in_ready); end
        rst_n = 1'b1;
        @(negedge clk);
        // Asynchronous reset while a result is held
        issue(4'd0, 32'h8000_0000, 32'h1, 32'h0, 1'b0, 1'b1);
        exp = exp_q.pop_front();
        n_compared++; if (out_valid !== 1'b1 || {flag, res} !== exp) begin n_mismatched++; $display("[TB] FAIL prereset_hold got v=%0b %b/%h want v=1 %b/%h", out_valid, flag, res, exp[33:32], exp[31:0]); end
        #2 rst_n = 1'b0;
        #1;
        n_compared++; if (out_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL async_reset_out_valid got %0b want 0", out_valid); end
        n_compared++; if (res !== 32'd0 || flag !== 2'b00) begin n_mismatched++; $display("[TB] FAIL async_reset_res got %b/%h want 00/0", flag, res); end
        n_compared++; if (in_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL async_reset_in_ready got %0b want 1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add_overflow();
        logic [33:0] exp;
        out_ready = 1'b1;
        n_compared++; if (in_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL add_in_ready got %0b want 1", in_ready); end
        issue(4'd0, 32'h7FFF_FFFF, 32'h1, 32'hDEAD_BEEF, 1'b0, 1'b1);
        exp = exp_q.pop_front();
        n_compared++; if (out_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL add_out_valid got %0b want 1", out_valid); end
        n_compared++; if (res !== exp[31:0] || res !== 32'h8000_0000) begin n_mismatched++; $display("[TB] FAIL add_res got %h want 80000000", res); end
        n_compared++; if (flag !== exp[33:32] || flag !== 2'b10) begin n_mismatched++; $display("[TB] FAIL add_flag got %b want 10", flag); end
        @(negedge clk);
        n_compared++; if (out_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL add_valid_drop got %0b want 0", out_valid); end
    endtask

    task automatic test_sub_imm();
        logic [33:0] exp;
        out_ready = 1'b1;
        issue(4'd1, 32'd5, 32'd123, 32'd5, 1'b1, 1'b1);
        exp = exp_q.pop_front();
        n_compared++; if (out_valid !== 1'b1 || res !== 32'd0 || res !== exp[31:0]) begin n_mismatched++; $display("[TB] FAIL sub_imm_res got v=%0b %h want v=1 0", out_valid, res); end
        n_compared++; if (flag !== 2'b01 || flag !== exp[33:32]) begin n_mismatched++; $display("[TB] FAIL sub_imm_flag got %b want 01", flag); end
        @(negedge clk);
    endtask

    logic [3:0]  t_op[13] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd8, 4'd8, 4'd12, 4'd15};
    logic [31:0] t_a[13]  = '{32'd3, 32'd3, 32'hF0F0_1234, 32'hF0F0_0000, 32'hFFFF_0000, 32'd1,
                              32'h8000_0000, 32'h8000_0000, 32'd1, 32'd2, 32'd0, 32'd77, 32'd9};
    logic [31:0] t_b[13]  = '{32'd4, 32'd5, 32'h0FF0_FF00, 32'h0000_000F, 32'h0F0F_0F0F, 32'hFFFF_FFE4,
                              32'd33, 32'd4, 32'd2, 32'd1, 32'hFFFF_FFFF, 32'd1, 32'd9};

    task automatic test_alu_ops();
        logic [33:0] exp;
        logic        sel;
        out_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            sel = i[0];
            if (sel) issue(t_op[i], t_a[i], $urandom, t_b[i], 1'b1, 1'b1);
            else     issue(t_op[i], t_a[i], t_b[i], $urandom, 1'b0, 1'b1);
            exp = exp_q.pop_front();
            n_compared++;
            if (out_valid !== 1'b1 || {flag, res} !== exp) begin
                n_mismatched++;
                $display("[TB] FAIL alu_op%0d_idx%0d got v=%0b %b/%h want v=1 %b/%h", t_op[i], i, out_valid, flag, res, exp[33:32], exp[31:0]);
            end
        end
        @(negedge clk);
    endtask

    task automatic run_iter(input string name, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [33:0] exp;
        int lat, busy;
        out_ready = 1'b1;
        issue(op, a, b, $urandom, 1'b0, 1'b1);
        wait_result(100, lat, busy);
        exp = exp_q.pop_front();
        n_compared++; if (lat != 33) begin n_mismatched++; $display("[TB] FAIL %s_latency got %0d want 33", name, lat); end
        n_compared++; if (busy != 32) begin n_mismatched++; $display("[TB] FAIL %s_busy_cycles got %0d want 32", name, busy); end
        n_compared++; if ({flag, res} !== exp) begin n_mismatched++; $display("[TB] FAIL %s_res got %b/%h want %b/%h", name, flag, res, exp[33:32], exp[31:0]); end
        @(negedge clk);
        n_compared++; if (out_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL %s_valid_drop got %0b want 0", name, out_valid); end
    endtask

    task automatic test_muldiv();
        run_iter("mul_ffff_x3", 4'd9, 32'hFFFF_FFFF, 32'd3);
        n_compared++; if (model(4'd9, 32'hFFFF_FFFF, 32'd3) !== {2'b10, 32'hFFFF_FFFD}) begin n_mismatched++; $display("[TB] FAIL mul_model got %h want 2fffffffd", model(4'd9, 32'hFFFF_FFFF, 32'd3)); end
        run_iter("divu_by0", 4'd10, 32'd100, 32'd0);
        run_iter("remu_by0", 4'd11, 32'd100, 32'd0);
        run_iter("divu_rand", 4'd10, $urandom, $urandom_range(1, 70000));
        run_iter("remu_rand", 4'd11, $urandom, $urandom_range(1, 70000));
        run_iter("mul_rand", 4'd9, $urandom, $urandom);
        run_iter("divu_big", 4'd10, 32'hFFFF_FFFF, 32'h8000_0001);
    endtask

    task automatic test_hold();
        logic [33:0] exp;
        logic [33:0] exp2;
        out_ready = 1'b0;
        issue(4'd4, 32'hA5A5_0000, 32'h0000_5A5A, 32'd0, 1'b0, 1'b1);
        exp = exp_q.pop_front();
        for (int c = 0; c < 5; c++) begin
            n_compared++;
            if (out_valid !== 1'b1 || {flag, res} !== exp || in_ready !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL hold_cycle%0d got v=%0b rdy=%0b %b/%h want v=1 rdy=0 %b/%h", c, out_valid, in_ready, flag, res, exp[33:32], exp[31:0]);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        n_compared++; if (in_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL hold_release_in_ready got %0b want 1", in_ready); end
        issue(4'd0, 32'd1000, 32'd24, 32'd0, 1'b0, 1'b1);
        exp2 = exp_q.pop_front();
        n_compared++; if (out_valid !== 1'b1 || {flag, res} !== exp2) begin n_mismatched++; $display("[TB] FAIL hold_then_add got v=%0b %b/%h want v=1 %b/%h", out_valid, flag, res, exp2[33:32], exp2[31:0]); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [33:0] exp;
        logic [3:0]  op;
        logic [31:0] a, b;
        out_ready = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            if (i > 0) begin
                exp = exp_q.pop_front();
                n_compared++;
                if (out_valid !== 1'b1 || {flag, res} !== exp) begin
                    n_mismatched++;
                    $display("[TB] FAIL b2b_%0d got v=%0b %b/%h want v=1 %b/%h", i, out_valid, flag, res, exp[33:32], exp[31:0]);
                end
            end
            if (i < 8) begin
                n_compared++; if (in_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL b2b_in_ready_%0d got %0b want 1", i, in_ready); end
                op = 4'($urandom_range(0, 8));
                a  = $urandom;
                b  = $urandom;
                alu_op = op; rD1 = a; rD2 = b; ext = ~b; alub_sel = 1'b0; in_valid = 1'b1;
                @(posedge clk);
                exp_q.push_back(model(op, a, b));
                @(negedge clk);
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_busy();
        logic [33:0] exp;
        int seen;
        out_ready = 1'b1;
        issue(4'd10, 32'd1000, 32'd7, 32'd0, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        n_compared++; if (in_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL busy_in_ready got %0b want 0", in_ready); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen++;
        end
        n_compared++; if (seen != 0) begin n_mismatched++; $display("[TB] FAIL aborted_div_valid got %0d cycles want 0", seen); end
        n_compared++; if (in_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL after_abort_in_ready got %0b want 1", in_ready); end
        issue(4'd0, 32'd2, 32'd2, 32'd0, 1'b0, 1'b1);
        exp = exp_q.pop_front();
        n_compared++; if (out_valid !== 1'b1 || res !== 32'd4 || {flag, res} !== exp) begin n_mismatched++; $display("[TB] FAIL after_abort_add got v=%0b %b/%h want v=1 00/4", out_valid, flag, res); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_sub_imm();
        test_alu_ops();
        test_muldiv();
        test_hold();
        test_back_to_back();
        test_reset_busy();
        n_compared++; if (exp_q.size() != 0) begin n_mismatched++; $display("[TB] FAIL scoreboard_leftover got %0d want 0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
